math_expression_inverse: RTL

- Inverse of the team's `math_expression` forward block. That block returns `q` and `rmd` for ((a-b)*(1+3c) - 4d)/2.
- This block takes `q`, `rmd`, `b`, `c`, `d` and recovers `a` with a multi-cycle signed restoring divider.
- It is used to cross-check and back-solve forward results in the same datapath.
- Start/busy/valid handshake; one result in flight at a time.

---
 rtl/math_expression_inverse.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/math_expression_inverse.sv
// math_expression_inverse
// Recovers operand a of the forward block ((a-b)*(1+3c) - 4d)/2 from its
// quotient q, remainder bit rmd and the other operands b, c, d.
// The division (q*2+rmd+4d)/(1+3c) runs on a signed restoring divider that
// produces one quotient bit per clock, followed by a sign fix-up step.
// Only one computation is in flight; start is ignored while busy.

module math_expression_inverse #(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] q,
    input  logic                rmd,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    input  logic signed [W-1:0] d,
    output logic signed [W-1:0] a,
    output logic                exact,
    output logic                div_err,
    output logic                valid,
    output logic                busy
);

    localparam int              CNT_W    = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [W-1:0]     ONE      = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_FIX
    } state_t;

    state_t r_state;

    // Operands captured at acceptance so the caller may change inputs freely
    logic [W-2:0]     r_qLow;
    logic             r_rmd;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_c;
    logic [W-1:0]     r_d;

    // Divider state: divisor magnitude, partial remainder, shifting quotient
    logic [W-1:0]     r_absD;
    logic [W:0]       r_rem;
    logic [W-1:0]     r_quo;
    logic             r_qNeg;
    logic [CNT_W-1:0] r_cnt;

    // The top bit of q is shifted out of N and plays no part in the result
    logic             w_unusedQMsb;

    logic [W-1:0]     w_n;
    logic [W-1:0]     w_x;
    logic [W-1:0]     w_dv;
    logic [W-1:0]     w_absX;
    logic [W-1:0]     w_absD;
    logic [W:0]       w_shift;
    logic [W:0]       w_sub;
    logic             w_ge;
    logic [W-1:0]     w_quoSigned;

    assign w_unusedQMsb = q[W-1];

    // Dividend X = 2q + rmd + 4d and divisor D = 1 + 3c, all modulo 2^W.
    // Magnitudes are unsigned, so -2^(W-1) naturally becomes 2^(W-1).
    assign w_n    = {r_qLow, r_rmd};
    assign w_x    = w_n + {r_d[W-3:0], 2'b00};
    assign w_dv   = r_c + {r_c[W-2:0], 1'b0} + ONE;
    assign w_absX = w_x[W-1]  ? (~w_x + ONE)  : w_x;
    assign w_absD = w_dv[W-1] ? (~w_dv + ONE) : w_dv;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign w_shift = {r_rem[W-1:0], r_quo[W-1]};
    assign w_sub   = w_shift - {1'b0, r_absD};
    assign w_ge    = (w_shift >= {1'b0, r_absD});

    // Quotient sign is X xor D; the remainder sign never matters for exact
    assign w_quoSigned = r_qNeg ? (~r_quo + ONE) : r_quo;

    // Control FSM and datapath registers with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_qLow  <= '0;
            r_rmd   <= 1'b0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_absD  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_qNeg  <= 1'b0;
            r_cnt   <= '0;
            a       <= '0;
            exact   <= 1'b0;
            div_err <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_qLow  <= q[W-2:0];
                        r_rmd   <= rmd;
                        r_b     <= b;
                        r_c     <= c;
                        r_d     <= d;
                        busy    <= 1'b1;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (w_dv == '0) begin
                        a       <= '0;
                        exact   <= 1'b0;
                        div_err <= 1'b1;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_absD  <= w_absD;
                        r_quo   <= w_absX;
                        r_rem   <= '0;
                        r_qNeg  <= w_x[W-1] ^ w_dv[W-1];
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_sub : w_shift;
                    r_quo <= {r_quo[W-2:0], w_ge};
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    a       <= w_quoSigned + r_b;
                    exact   <= (r_rem == '0);
                    div_err <= 1'b0;
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
